alu_issue_decoder: RTL

ALU_ISSUE_DECODER -- requirements
Module: alu_issue_decoder

---
 rtl/alu_issue_decoder_pkg.sv | 113 +++++++++++
 rtl/alu_issue_decoder_if.sv | 36 +++
 rtl/alu_issue_decoder_skid_buffer.sv | 70 +++++++
 rtl/alu_issue_decoder.sv | 72 +++++++
 4 files changed

// File: rtl/alu_issue_decoder_pkg.sv
// Shared ALU op encoding, RV32I field constants and the decoded bundle.
// Also holds the pure combinational decode function.
package alu_issue_decoder_pkg;

    typedef enum logic [4:0] {
        ALU_ADD     = 5'h00,
        ALU_SUB     = 5'h01,
        ALU_XOR     = 5'h02,
        ALU_OR      = 5'h03,
        ALU_AND     = 5'h04,
        ALU_SLL     = 5'h05,
        ALU_SRL     = 5'h06,
        ALU_SRA     = 5'h07,
        ALU_SLT     = 5'h08,
        ALU_SLTU    = 5'h09,
        ALU_ADDI    = 5'h0A,
        ALU_XORI    = 5'h0B,
        ALU_ORI     = 5'h0C,
        ALU_ANDI    = 5'h0D,
        ALU_SLLI    = 5'h0E,
        ALU_SRLI    = 5'h0F,
        ALU_SRAI    = 5'h10,
        ALU_SLTI    = 5'h11,
        ALU_ILLEGAL = 5'h1F
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
    } dec_bundle_t;

    function automatic dec_bundle_t decode(input logic [31:0] instr);
        dec_bundle_t b;
        alu_op_e     op;
        logic        is_imm;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        opc = instr[6:0];
        f3  = instr[14:12];
        f7  = instr[31:25];
        op     = ALU_ILLEGAL;
        is_imm = 1'b0;
        b.rs1  = instr[19:15];
        b.rs2  = instr[24:20];
        b.rd   = instr[11:7];
        b.imm  = {{20{instr[31]}}, instr[31:20]};
        unique case (1'b1)
            (opc == OPC_OP): begin
                case (f3)
                    F3_ADD:  op = (f7 == F7_BASE) ? ALU_ADD :
                                  (f7 == F7_ALT)  ? ALU_SUB : ALU_ILLEGAL;
                    F3_SLL:  op = (f7 == F7_BASE) ? ALU_SLL  : ALU_ILLEGAL;
                    F3_SLT:  op = (f7 == F7_BASE) ? ALU_SLT  : ALU_ILLEGAL;
                    F3_SLTU: op = (f7 == F7_BASE) ? ALU_SLTU : ALU_ILLEGAL;
                    F3_XOR:  op = (f7 == F7_BASE) ? ALU_XOR  : ALU_ILLEGAL;
                    F3_SR:   op = (f7 == F7_BASE) ? ALU_SRL :
                                  (f7 == F7_ALT)  ? ALU_SRA : ALU_ILLEGAL;
                    F3_OR:   op = (f7 == F7_BASE) ? ALU_OR   : ALU_ILLEGAL;
                    F3_AND:  op = (f7 == F7_BASE) ? ALU_AND  : ALU_ILLEGAL;
                    default: op = ALU_ILLEGAL;
                endcase
            end
            (opc == OPC_OP_IMM): begin
                is_imm = 1'b1;
                case (f3)
                    F3_ADD:  op = ALU_ADDI;
                    F3_SLT:  op = ALU_SLTI;
                    F3_SLTU: op = ALU_SLTU;
                    F3_XOR:  op = ALU_XORI;
                    F3_OR:   op = ALU_ORI;
                    F3_AND:  op = ALU_ANDI;
                    F3_SLL: begin
                        op    = (f7 == F7_BASE) ? ALU_SLLI : ALU_ILLEGAL;
                        b.imm = {27'b0, instr[24:20]};
                    end
                    F3_SR: begin
                        op    = (f7 == F7_BASE) ? ALU_SRLI :
                                (f7 == F7_ALT)  ? ALU_SRAI : ALU_ILLEGAL;
                        b.imm = {27'b0, instr[24:20]};
                    end
                    default: op = ALU_ILLEGAL;
                endcase
            end
            default: op = ALU_ILLEGAL;
        endcase
        b.alu_op  = op;
        b.illegal = (op == ALU_ILLEGAL);
        b.use_imm = is_imm & ~b.illegal;
        return b;
    endfunction

endpackage

// File: rtl/alu_issue_decoder_if.sv
// Upstream instruction handshake, downstream bundle handshake and
// the transfer counters of the issue decoder.
interface alu_issue_decoder_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_alu_op;
    logic [4:0]       out_rs1_addr;
    logic [4:0]       out_rs2_addr;
    logic [4:0]       out_rd_addr;
    logic [31:0]      out_imm;
    logic             out_use_imm;
    logic             out_illegal;
    logic [CNT_W-1:0] decoded_cnt;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_alu_op,
        input  out_rs1_addr, out_rs2_addr, out_rd_addr,
        input  out_imm, out_use_imm, out_illegal,
        input  decoded_cnt, illegal_cnt
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_alu_op,
        output out_rs1_addr, out_rs2_addr, out_rd_addr,
        output out_imm, out_use_imm, out_illegal,
        output decoded_cnt, illegal_cnt
    );
endinterface

// File: rtl/alu_issue_decoder_skid_buffer.sv
// Two-entry skid buffer: output register plus one skid register.
// in_ready comes straight from a flop so upstream sees no comb path.
module skid_buffer #(
    parameter type T = logic [31:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);
    T     out_q, out_d;
    T     skid_q, skid_d;
    logic out_vld_q, out_vld_d;
    logic skid_vld_q, skid_vld_d;
    logic ready_q;
    logic in_fire;
    logic out_free;

    assign in_fire  = in_valid_i & ready_q;
    assign out_free = ~out_vld_q | out_ready_i;

    // Refill the output slot from skid first (oldest), else from input;
    // a stalled output diverts a new word into the skid slot.
    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (out_free) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = in_fire;
                if (in_fire) begin
                    out_d = in_data_i;
                end
            end
        end else if (in_fire) begin
            skid_d     = in_data_i;
            skid_vld_d = 1'b1;
        end
    end

    // Buffer state; reset empties both entries and zeroes payloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            ready_q    <= ~skid_vld_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = out_vld_q;
    assign out_data_o  = out_q;
endmodule

// File: rtl/alu_issue_decoder.sv
// RV32I ALU issue decoder: comb decode feeding a skid buffer,
// plus saturating counters of delivered and illegal bundles.
module alu_issue_decoder
    import alu_issue_decoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    alu_issue_decoder_if.slave bus
);
    dec_bundle_t      dec_b;
    dec_bundle_t      out_b;
    logic             out_vld;
    logic             out_fire;
    logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

    // Decode the presented word ahead of the buffer.
    always_comb begin
        dec_b = decode(bus.in_instr);
    end

    skid_buffer #(
        .T(dec_bundle_t)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .in_data_i   (dec_b),
        .out_valid_o (out_vld),
        .out_ready_i (bus.out_ready),
        .out_data_o  (out_b)
    );

    assign out_fire = out_vld & bus.out_ready;

    // Count delivered bundles, holding at all-ones.
    always_comb begin
        dec_cnt_d = dec_cnt_q;
        ill_cnt_d = ill_cnt_q;
        if (out_fire && (dec_cnt_q != '1)) begin
            dec_cnt_d = dec_cnt_q + CNT_W'(1);
        end
        if (out_fire && out_b.illegal && (ill_cnt_q != '1)) begin
            ill_cnt_d = ill_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt_q <= '0;
            ill_cnt_q <= '0;
        end else begin
            dec_cnt_q <= dec_cnt_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign bus.out_valid    = out_vld;
    assign bus.out_alu_op   = out_b.alu_op;
    assign bus.out_rs1_addr = out_b.rs1;
    assign bus.out_rs2_addr = out_b.rs2;
    assign bus.out_rd_addr  = out_b.rd;
    assign bus.out_imm      = out_b.imm;
    assign bus.out_use_imm  = out_b.use_imm;
    assign bus.out_illegal  = out_b.illegal;
    assign bus.decoded_cnt  = dec_cnt_q;
    assign bus.illegal_cnt  = ill_cnt_q;
endmodule
